// File: rtl/ct_idu_rf_prf_preg_bank.sv
// Physical-register bank: DEPTH x WIDTH pregs, NUM_WP writeback ports, NUM_RP registered
// read ports, per-entry clock-enable gating, ready scoreboard, write bypass and collision error.
module ct_idu_rf_prf_preg_bank #(
    parameter int WIDTH  = 64,
    parameter int DEPTH  = 32,
    parameter int NUM_WP = 3,
    parameter int NUM_RP = 2,
    parameter int BYPASS = 1,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic                      forever_cpuclk,
    input  logic                      cpurst,
    input  logic                      cp0_yy_clk_en,
    input  logic                      cp0_idu_icg_en,
    input  logic                      pad_yy_icg_scan_en,
    input  logic [NUM_WP-1:0]         x_wb_vld,
    input  logic [NUM_WP*IDX_W-1:0]   x_wb_preg,
    input  logic [NUM_WP*WIDTH-1:0]   x_wb_data,
    input  logic                      alloc_vld,
    input  logic [IDX_W-1:0]          alloc_preg,
    input  logic [NUM_RP-1:0]         rd_vld,
    input  logic [NUM_RP*IDX_W-1:0]   rd_preg,
    output logic [NUM_RP*WIDTH-1:0]   rd_data,
    output logic [NUM_RP-1:0]         rd_rdy,
    output logic [DEPTH-1:0]          preg_rdy,
    output logic                      wb_conflict_err,
    input  logic                      err_clr
);

    logic [WIDTH-1:0]            mem [DEPTH];
    logic [DEPTH-1:0]            wr_hit;
    logic [DEPTH-1:0]            wr_multi;
    logic [DEPTH-1:0][WIDTH-1:0] wr_data_e;
    logic [DEPTH-1:0]            alloc_hit;
    logic [DEPTH-1:0]            ent_clk_en;
    logic                        collision;

    // Ports scanned high to low so the lowest-numbered port's data is the one left standing.
    always_comb begin
        wr_hit    = '0;
        wr_multi  = '0;
        wr_data_e = '0;
        for (int i = 0; i < DEPTH; i++) begin
            for (int p = NUM_WP - 1; p >= 0; p--) begin
                if (x_wb_vld[p] && (x_wb_preg[p*IDX_W +: IDX_W] == IDX_W'(i))) begin
                    if (wr_hit[i])
                        wr_multi[i] = 1'b1;
                    wr_hit[i]    = 1'b1;
                    wr_data_e[i] = x_wb_data[p*WIDTH +: WIDTH];
                end
            end
        end
    end

    assign alloc_hit = alloc_vld ? (DEPTH'(1) << alloc_preg) : '0;
    assign collision = (|wr_multi) | (|(wr_hit & alloc_hit));

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_ent
            // Gated-clock enable of the entry; cpurst is part of the local enable.
            assign ent_clk_en[gi] = (cp0_yy_clk_en & (cp0_idu_icg_en | wr_hit[gi] | cpurst))
                                  | pad_yy_icg_scan_en;

            always_ff @(posedge forever_cpuclk) begin
                if (cpurst)
                    mem[gi] <= '0;
                else if (ent_clk_en[gi] && wr_hit[gi])
                    mem[gi] <= wr_data_e[gi];
            end
        end
    endgenerate

    // Alloc masks the write hit, so a same-cycle alloc+write leaves the entry not ready.
    always_ff @(posedge forever_cpuclk) begin
        if (cpurst)
            preg_rdy <= '1;
        else
            preg_rdy <= (preg_rdy | wr_hit) & ~alloc_hit;
    end

    always_ff @(posedge forever_cpuclk) begin
        if (cpurst)
            wb_conflict_err <= 1'b0;
        else if (collision)
            wb_conflict_err <= 1'b1;
        else if (err_clr)
            wb_conflict_err <= 1'b0;
    end

    logic [WIDTH-1:0] rd_data_q [NUM_RP];
    logic [NUM_RP-1:0] rd_clk_en;

    genvar gr;
    generate
        for (gr = 0; gr < NUM_RP; gr++) begin : g_rd
            logic [IDX_W-1:0] idx;
            logic [WIDTH-1:0] nxt_data;
            logic             nxt_rdy;

            assign idx = rd_preg[gr*IDX_W +: IDX_W];
            assign rd_clk_en[gr] = (cp0_yy_clk_en & (cp0_idu_icg_en | rd_vld[gr] | cpurst))
                                 | pad_yy_icg_scan_en;

            always_comb begin
                nxt_data = mem[idx];
                nxt_rdy  = preg_rdy[idx];
                if ((BYPASS != 0) && wr_hit[idx]) begin
                    nxt_data = wr_data_e[idx];
                    nxt_rdy  = 1'b1;
                end
            end

            always_ff @(posedge forever_cpuclk) begin
                if (cpurst) begin
                    rd_data_q[gr] <= '0;
                    rd_rdy[gr]    <= 1'b0;
                end else if (rd_clk_en[gr] && rd_vld[gr]) begin
                    rd_data_q[gr] <= nxt_data;
                    rd_rdy[gr]    <= nxt_rdy;
                end
            end

            assign rd_data[gr*WIDTH +: WIDTH] = rd_data_q[gr];
        end
    endgenerate

endmodule
